ysyx_22040895_fetch_ctrl: RTL and testbench

Sequences instruction fetch for the NPC core. Owns the fetch PC and issues one request at a time to instruction memory over a req/gnt + rvalid handshake. Presents each fetched instruction with its PC to the decode side over a valid/ready handshake. Applies control-flow redirects (pcsel/dnpc from EXU) and discards any stale in-flight fetch.

---
 rtl/ysyx_22040895_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_ysyx_22040895_fetch_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040895_fetch_ctrl.sv
// ysyx_22040895_fetch_ctrl
// Instruction fetch sequencer for the NPC core. Owns the fetch PC, issues at
// most one outstanding request to instruction memory (req/gnt + rvalid), and
// hands each returned instruction with its PC to decode (valid/ready).
// Redirects from EXU (pcsel/dnpc) override normal sequencing and any fetch
// already in flight is marked to be discarded.
//
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   mem_req_o/addr_o     fetch request and address (address stable in REQ)
//   mem_gnt_i            memory accepted the request
//   mem_rvalid_i/rdata_i returned instruction
//   out_valid_o/inst_o/pc_o, out_ready_i   decode handshake
//   redirect_i/pc_i      control-flow redirect and target
//   fetch_cnt_o          instructions handed to decode (wraps)
module ysyx_22040895_fetch_ctrl #(
  parameter int unsigned         ADDR_W   = 64,
  parameter int unsigned         INST_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = 64'h8000_0000,
  parameter int unsigned         CNT_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  output logic              out_valid_o,
  output logic [INST_W-1:0] out_inst_o,
  output logic [ADDR_W-1:0] out_pc_o,
  input  logic              out_ready_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e              state_q,     state_d;
  logic [ADDR_W-1:0]   fetch_pc_q,  fetch_pc_d;
  logic [ADDR_W-1:0]   req_pc_q,    req_pc_d;
  logic                drop_q,      drop_d;
  logic [INST_W-1:0]   out_inst_q,  out_inst_d;
  logic [ADDR_W-1:0]   out_pc_q,    out_pc_d;
  logic [CNT_W-1:0]    fetch_cnt_q, fetch_cnt_d;

  // Redirect targets are word aligned: low two bits are cleared.
  logic [ADDR_W-1:0] redirect_tgt;
  assign redirect_tgt = redirect_pc_i & ~ADDR_W'(3);

  // Outputs derive from registered state only, except out_valid_o which a
  // same-cycle redirect must be able to kill.
  assign mem_req_o   = (state_q == S_REQ);
  assign mem_addr_o  = fetch_pc_q;
  assign out_valid_o = (state_q == S_HOLD) && !redirect_i;
  assign out_inst_o  = out_inst_q;
  assign out_pc_o    = out_pc_q;
  assign fetch_cnt_o = fetch_cnt_q;

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    drop_d      = drop_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    fetch_cnt_d = fetch_cnt_q;

    if (redirect_i) fetch_pc_d = redirect_tgt;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        if (mem_gnt_i) begin
          req_pc_d = fetch_pc_q;
          state_d  = S_WAIT;
          // The old-PC request was accepted together with the redirect, so
          // its response must be thrown away.
          if (redirect_i) drop_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (mem_rvalid_i) begin
          if (redirect_i || drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            out_inst_d = mem_rdata_i;
            out_pc_d   = req_pc_q;
            state_d    = S_HOLD;
          end
        end else if (redirect_i) begin
          drop_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (redirect_i) begin
          state_d = S_REQ;
        end else if (out_ready_i) begin
          fetch_pc_d  = req_pc_q + ADDR_W'(4);
          fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
          state_d     = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      drop_q      <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= RESET_PC;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      drop_q      <= drop_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_fetch_ctrl.sv
// Directed testbench for ysyx_22040895_fetch_ctrl. Inputs change 1 ns after
// the rising edge; outputs are sampled in that same gap.
module tb_ysyx_22040895_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_o;
  logic [63:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        out_valid_o;
  logic [31:0] out_inst_o;
  logic [63:0] out_pc_o;
  logic        out_ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic [63:0] fetch_cnt_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Values captured by fetch_cycle.
  logic        a_req, a_valid;
  logic [63:0] a_addr, a_pc;
  logic [31:0] a_inst;

  ysyx_22040895_fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .out_valid_o(out_valid_o), .out_inst_o(out_inst_o), .out_pc_o(out_pc_o),
    .out_ready_i(out_ready_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .fetch_cnt_o(fetch_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting in REQ: grant now, return inst next cycle, accept in HOLD.
  // Ends in REQ for the following fetch.
  task automatic fetch_cycle(input logic [31:0] inst);
    a_req  = mem_req_o;
    a_addr = mem_addr_o;
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = inst;
    tick();
    mem_rvalid_i = 1'b0;
    a_valid = out_valid_o;
    a_pc    = out_pc_o;
    a_inst  = out_inst_o;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    total_cnt++; if (mem_req_o !== 1'b0) $display("FAIL reset_req got=%b exp=0", mem_req_o); else pass_cnt++;
    total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid_o); else pass_cnt++;
    total_cnt++; if (out_pc_o !== 64'h8000_0000) $display("FAIL reset_pc got=%h exp=%h", out_pc_o, 64'h8000_0000); else pass_cnt++;
    total_cnt++; if (out_inst_o !== 32'h0) $display("FAIL reset_inst got=%h exp=0", out_inst_o); else pass_cnt++;
    total_cnt++; if (fetch_cnt_o !== 64'd0) $display("FAIL reset_cnt got=%0d exp=0", fetch_cnt_o); else pass_cnt++;
    rst = 1'b1;
    tick();  // IDLE bubble -> REQ
  endtask

  task automatic test_free_run();
    logic [63:0] exp_addr;
    logic [31:0] inst;
    for (int i = 0; i < 3; i++) begin
      exp_addr = 64'h8000_0000 + 64'(4 * i);
      inst     = 32'h0000_0013 + 32'(i << 8);
      fetch_cycle(inst);
      total_cnt++; if (a_req !== 1'b1) $display("FAIL run_req[%0d] got=%b exp=1", i, a_req); else pass_cnt++;
      total_cnt++; if (a_addr !== exp_addr) $display("FAIL run_addr[%0d] got=%h exp=%h", i, a_addr, exp_addr); else pass_cnt++;
      total_cnt++; if (a_valid !== 1'b1) $display("FAIL run_valid[%0d] got=%b exp=1", i, a_valid); else pass_cnt++;
      total_cnt++; if (a_pc !== exp_addr) $display("FAIL run_pc[%0d] got=%h exp=%h", i, a_pc, exp_addr); else pass_cnt++;
      total_cnt++; if (a_inst !== inst) $display("FAIL run_inst[%0d] got=%h exp=%h", i, a_inst, inst); else pass_cnt++;
    end
    total_cnt++; if (fetch_cnt_o !== 64'd3) $display("FAIL run_cnt got=%0d exp=3", fetch_cnt_o); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hAABB_CCDD;
    tick();
    // Spurious rvalid while in HOLD must be ignored.
    mem_rdata_i = 32'h5555_5555;
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (out_valid_o !== 1'b1) $display("FAIL bp_valid[%0d] got=%b exp=1", i, out_valid_o); else pass_cnt++;
      total_cnt++; if (out_inst_o !== 32'hAABB_CCDD) $display("FAIL bp_inst[%0d] got=%h exp=aabbccdd", i, out_inst_o); else pass_cnt++;
      total_cnt++; if (out_pc_o !== 64'h8000_000C) $display("FAIL bp_pc[%0d] got=%h exp=8000000c", i, out_pc_o); else pass_cnt++;
      total_cnt++; if (mem_req_o !== 1'b0) $display("FAIL bp_req[%0d] got=%b exp=0", i, mem_req_o); else pass_cnt++;
      total_cnt++; if (fetch_cnt_o !== 64'd3) $display("FAIL bp_cnt[%0d] got=%0d exp=3", i, fetch_cnt_o); else pass_cnt++;
      tick();
    end
    mem_rvalid_i = 1'b0;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    total_cnt++; if (fetch_cnt_o !== 64'd4) $display("FAIL bp_cnt_after got=%0d exp=4", fetch_cnt_o); else pass_cnt++;
    total_cnt++; if (mem_addr_o !== 64'h8000_0010) $display("FAIL bp_next_addr got=%h exp=80000010", mem_addr_o); else pass_cnt++;
  endtask

  task automatic test_redirect_hold();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'h1234_5678;
    tick();
    mem_rvalid_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_1002;
    out_ready_i = 1'b1;
    #1;
    total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL rh_valid got=%b exp=0", out_valid_o); else pass_cnt++;
    tick();
    redirect_i = 1'b0;
    out_ready_i = 1'b0;
    total_cnt++; if (mem_req_o !== 1'b1) $display("FAIL rh_req got=%b exp=1", mem_req_o); else pass_cnt++;
    total_cnt++; if (mem_addr_o !== 64'h8000_1000) $display("FAIL rh_addr got=%h exp=80001000", mem_addr_o); else pass_cnt++;
    total_cnt++; if (fetch_cnt_o !== 64'd4) $display("FAIL rh_cnt got=%0d exp=4", fetch_cnt_o); else pass_cnt++;
    fetch_cycle(32'h0000_1111);
    total_cnt++; if (a_pc !== 64'h8000_1000) $display("FAIL rh_pc got=%h exp=80001000", a_pc); else pass_cnt++;
    total_cnt++; if (fetch_cnt_o !== 64'd5) $display("FAIL rh_cnt2 got=%0d exp=5", fetch_cnt_o); else pass_cnt++;
  endtask

  task automatic test_redirect_wait();
    mem_gnt_i = 1'b1;
    tick();  // WAIT for 0x80001004
    mem_gnt_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_0100;
    tick();  // still WAIT, drop set
    redirect_i = 1'b0;
    total_cnt++; if (mem_req_o !== 1'b0) $display("FAIL rw_req_wait got=%b exp=0", mem_req_o); else pass_cnt++;
    tick();
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hDEAD_BEEF;
    tick();  // stale data dropped -> REQ
    mem_rvalid_i = 1'b0;
    total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL rw_valid got=%b exp=0", out_valid_o); else pass_cnt++;
    total_cnt++; if (mem_addr_o !== 64'h8000_0100) $display("FAIL rw_addr got=%h exp=80000100", mem_addr_o); else pass_cnt++;
    fetch_cycle(32'h2222_2222);
    total_cnt++; if (a_valid !== 1'b1) $display("FAIL rw_valid2 got=%b exp=1", a_valid); else pass_cnt++;
    total_cnt++; if (a_pc !== 64'h8000_0100) $display("FAIL rw_pc got=%h exp=80000100", a_pc); else pass_cnt++;
    total_cnt++; if (a_inst !== 32'h2222_2222) $display("FAIL rw_inst got=%h exp=22222222", a_inst); else pass_cnt++;
    total_cnt++; if (fetch_cnt_o !== 64'd6) $display("FAIL rw_cnt got=%0d exp=6", fetch_cnt_o); else pass_cnt++;
  endtask

  task automatic test_redirect_coincident();
    // Redirect together with gnt in REQ (at 0x80000104).
    mem_gnt_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_0200;
    tick();
    mem_gnt_i = 1'b0;
    redirect_i = 1'b0;
    total_cnt++; if (mem_req_o !== 1'b0) $display("FAIL rg_req got=%b exp=0", mem_req_o); else pass_cnt++;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hBAD0_BAD0;
    tick();
    mem_rvalid_i = 1'b0;
    total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL rg_valid got=%b exp=0", out_valid_o); else pass_cnt++;
    total_cnt++; if (mem_addr_o !== 64'h8000_0200) $display("FAIL rg_addr got=%h exp=80000200", mem_addr_o); else pass_cnt++;
    fetch_cycle(32'h3333_3333);
    total_cnt++; if (a_pc !== 64'h8000_0200) $display("FAIL rg_pc got=%h exp=80000200", a_pc); else pass_cnt++;
    total_cnt++; if (fetch_cnt_o !== 64'd7) $display("FAIL rg_cnt got=%0d exp=7", fetch_cnt_o); else pass_cnt++;

    // Redirect together with rvalid in WAIT (request at 0x80000204).
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_0300;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'h4444_4444;
    tick();
    redirect_i = 1'b0;
    mem_rvalid_i = 1'b0;
    total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL rv_valid got=%b exp=0", out_valid_o); else pass_cnt++;
    total_cnt++; if (mem_req_o !== 1'b1) $display("FAIL rv_req got=%b exp=1", mem_req_o); else pass_cnt++;
    total_cnt++; if (mem_addr_o !== 64'h8000_0300) $display("FAIL rv_addr got=%h exp=80000300", mem_addr_o); else pass_cnt++;
    fetch_cycle(32'h5555_0000);
    total_cnt++; if (a_valid !== 1'b1) $display("FAIL rv_valid2 got=%b exp=1", a_valid); else pass_cnt++;
    total_cnt++; if (a_pc !== 64'h8000_0300) $display("FAIL rv_pc got=%h exp=80000300", a_pc); else pass_cnt++;
    total_cnt++; if (fetch_cnt_o !== 64'd8) $display("FAIL rv_cnt got=%0d exp=8", fetch_cnt_o); else pass_cnt++;

    // Redirect in REQ without gnt: address moves next cycle.
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_0403;
    tick();
    redirect_i = 1'b0;
    total_cnt++; if (mem_req_o !== 1'b1) $display("FAIL rr_req got=%b exp=1", mem_req_o); else pass_cnt++;
    total_cnt++; if (mem_addr_o !== 64'h8000_0400) $display("FAIL rr_addr got=%h exp=80000400", mem_addr_o); else pass_cnt++;
    fetch_cycle(32'h6666_6666);
    total_cnt++; if (fetch_cnt_o !== 64'd9) $display("FAIL rr_cnt got=%0d exp=9", fetch_cnt_o); else pass_cnt++;
  endtask

  task automatic test_wrap();
    redirect_i = 1'b1;
    redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect_i = 1'b0;
    total_cnt++; if (mem_addr_o !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_addr got=%h exp=fffffffffffffffc", mem_addr_o); else pass_cnt++;
    fetch_cycle(32'h7777_7777);
    total_cnt++; if (a_pc !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_pc got=%h exp=fffffffffffffffc", a_pc); else pass_cnt++;
    total_cnt++; if (mem_addr_o !== 64'h0) $display("FAIL wrap_next got=%h exp=0", mem_addr_o); else pass_cnt++;
    total_cnt++; if (fetch_cnt_o !== 64'd10) $display("FAIL wrap_cnt got=%0d exp=10", fetch_cnt_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    mem_gnt_i = 1'b1;
    tick();  // WAIT for address 0
    mem_gnt_i = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    total_cnt++; if (mem_req_o !== 1'b0) $display("FAIL rm_req got=%b exp=0", mem_req_o); else pass_cnt++;
    total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL rm_valid got=%b exp=0", out_valid_o); else pass_cnt++;
    total_cnt++; if (out_pc_o !== 64'h8000_0000) $display("FAIL rm_pc got=%h exp=80000000", out_pc_o); else pass_cnt++;
    total_cnt++; if (out_inst_o !== 32'h0) $display("FAIL rm_inst got=%h exp=0", out_inst_o); else pass_cnt++;
    total_cnt++; if (fetch_cnt_o !== 64'd0) $display("FAIL rm_cnt got=%0d exp=0", fetch_cnt_o); else pass_cnt++;
    tick();
    total_cnt++; if (mem_req_o !== 1'b1) $display("FAIL rm_req2 got=%b exp=1", mem_req_o); else pass_cnt++;
    total_cnt++; if (mem_addr_o !== 64'h8000_0000) $display("FAIL rm_addr got=%h exp=80000000", mem_addr_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect_hold();
    test_redirect_wait();
    test_redirect_coincident();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
